if_stage: RTL and testbench

Instruction-fetch stage of the RV32I pipeline: owns the program counter, issues word fetches to the instruction memory over a single-outstanding request/response interface, and drives the IF/ID pipeline register whose instruction word feeds the instruction decoder. It honours stall requests from the hazard unit, flushes from branch resolution and PC redirects. It discards in-flight fetches made stale by a redirect.

---
 rtl/if_stage.sv | 190 +++++++++++++++++++
 tb/tb_if_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction-fetch stage with single-outstanding imem port and IF/ID register
//
// Owns the program counter, fetches one word at a time from instruction
// memory and loads the IF/ID register that feeds the decoder. Fetches made
// stale by a redirect are tracked and their responses discarded.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   stall_i                hold PC and IF/ID contents
//   flush_i                replace IF/ID contents with a bubble
//   redirect_i             load redirect_pc_i (word-aligned) and kill any in-flight fetch
//   redirect_pc_i          redirect target, bits [1:0] ignored
//   imem_req_o/addr_o      one-cycle fetch request and its word-aligned address
//   imem_rvalid_i/rdata_i  fetch response
//   if_id_*_o              registered instruction, its PC, PC+4 and valid flag
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic        if_id_valid_o
);

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_DROP,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc_i[31:2], 2'b00};
    assign pc_plus4             = pc_q + 32'd4;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Moore request: depends only on state, gated by reset so nothing is
    // requested while rst_ni is low.
    assign imem_req_o  = rst_ni && (state_q == S_ISSUE);
    assign imem_addr_o = pc_q;

    // Fetch FSM. A response is only accepted in WAIT (live fetch) or DROP
    // (stale fetch); in ISSUE and HOLD nothing is outstanding, so a stray
    // rvalid there is ignored.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        deliver       = 1'b0;
        deliver_instr = imem_rdata_i;
        deliver_pc    = pc_q;

        case (state_q)
            S_ISSUE: begin
                if (redirect_i) begin
                    // The request going out this cycle is already stale.
                    pc_d    = redirect_target;
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_i) begin
                        pc_d    = redirect_target;
                        state_d = S_ISSUE;
                    end else if (stall_i) begin
                        hold_instr_d = imem_rdata_i;
                        hold_pc_d    = pc_q;
                        state_d      = S_HOLD;
                    end else begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = S_ISSUE;
                    end
                end else if (redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // Further redirects just retarget; the stale response still
                // has to be absorbed before a new request may go out.
                if (redirect_i) begin
                    pc_d = redirect_target;
                end
                if (imem_rvalid_i) begin
                    state_d = S_ISSUE;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    hold_instr_d = '0;
                    hold_pc_d    = '0;
                    pc_d         = redirect_target;
                    state_d      = S_ISSUE;
                end else if (!stall_i) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr_q;
                    deliver_pc    = hold_pc_q;
                    pc_d          = pc_plus4;
                    state_d       = S_ISSUE;
                end
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    // IF/ID register: flush > stall > deliver > bubble. Bubbles and flushes
    // keep the PC fields so the decoder side sees stable values.
    always_comb begin
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;

        if (flush_i) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (stall_i) begin
            if_id_valid_d = if_id_valid_q;
        end else if (deliver) begin
            if_id_instr_d    = deliver_instr;
            if_id_pc_d       = deliver_pc;
            if_id_pc_plus4_d = deliver_pc + 32'd4;
            if_id_valid_d    = 1'b1;
        end else begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= S_ISSUE;
            pc_q             <= RESET_PC;
            hold_instr_q     <= '0;
            hold_pc_q        <= '0;
            if_id_instr_q    <= NOP_INSTR;
            if_id_pc_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd4;
            if_id_valid_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            hold_instr_q     <= hold_instr_d;
            hold_pc_q        <= hold_pc_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
        end
    end

    assign if_id_instr_o    = if_id_instr_q;
    assign if_id_pc_o       = if_id_pc_q;
    assign if_id_pc_plus4_o = if_id_pc_plus4_q;
    assign if_id_valid_o    = if_id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with memory responder and delivery scoreboard
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i;
    logic        rst_ni;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        if_id_valid_o;

    if_stage dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_id_instr_o    (if_id_instr_o),
        .if_id_pc_o       (if_id_pc_o),
        .if_id_pc_plus4_o (if_id_pc_plus4_o),
        .if_id_valid_o    (if_id_valid_o)
    );

    int          checks = 0;
    int          errors = 0;
    int          k = 1;
    int          cyc;
    int          stray_set = 0;
    int          stray_done = 0;
    logic        stray_now = 1'b0;
    int          delivered = 0;
    logic        stall_edge = 1'b0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];

    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = '0;
    logic        rsp_stale = 1'b0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    always @(posedge clk_i) stall_edge <= stall_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return {a[15:0], a[31:16]} ^ 32'h00A0_0013;
    endfunction

    // Memory responder: answers each request k cycles later. A fetch is stale
    // (no delivery expected) if redirect_i is seen from its request cycle up
    // to and including its response cycle; reset forgets it entirely.
    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            #2;
            imem_rvalid_i = 1'b0;
            stray_now     = 1'b0;
            if (!rst_ni) begin
                rsp_cnt = 0;
            end else begin
                if (rsp_cnt > 0) begin
                    if (redirect_i) rsp_stale = 1'b1;
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        imem_rvalid_i = 1'b1;
                        imem_rdata_i  = mem_word(rsp_addr);
                        if (!rsp_stale) begin
                            exp_pc_q.push_back(rsp_addr);
                            exp_instr_q.push_back(mem_word(rsp_addr));
                        end
                    end
                end
                if (stray_set != stray_done) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = 32'hDEAD_BEEF;
                    stray_now     = 1'b1;
                    stray_done    = stray_set;
                end
                if (imem_req_o) begin
                    req_addr_q.push_back(imem_addr_o);
                    req_cyc_q.push_back(cyc);
                    rsp_addr  = imem_addr_o;
                    rsp_cnt   = k;
                    rsp_stale = redirect_i;
                end
            end
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && imem_req_o && imem_rvalid_i && !stray_now)
            assert (0) else $error("protocol violation: rvalid while a request is being issued");
    end

    // Scoreboard: a fresh load of IF/ID is a valid word that was not held by
    // a stall at the preceding edge.
    initial begin
        logic [31:0] ep, ei;
        forever begin
            @(negedge clk_i);
            if (rst_ni && if_id_valid_o && !stall_edge) begin
                if (exp_pc_q.size() == 0) begin
                    check("sb_unexpected", 32'(exp_pc_q.size()), 32'd1);
                end else begin
                    ep = exp_pc_q.pop_front();
                    ei = exp_instr_q.pop_front();
                    check("sb_instr", if_id_instr_o, ei);
                    check("sb_pc", if_id_pc_o, ep);
                    check("sb_pc4", if_id_pc_plus4_o, ep + 32'd4);
                    delivered++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_req(output logic [31:0] a);
        a = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (imem_req_o) begin
                a = imem_addr_o;
                return;
            end
        end
        check("req_timeout", {31'b0, imem_req_o}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req"},   {31'b0, imem_req_o}, 32'd0);
        check({pfx, "_addr"},  imem_addr_o, 32'd0);
        check({pfx, "_instr"}, if_id_instr_o, NOP);
        check({pfx, "_pc"},    if_id_pc_o, 32'd0);
        check({pfx, "_pc4"},   if_id_pc_plus4_o, 32'd4);
        check({pfx, "_valid"}, {31'b0, if_id_valid_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          base;
        int          d0;
        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        tick(3);
        check_reset_outputs("rst");

        // c0: first request right after release
        rst_ni = 1'b1;
        #1;
        check("c0_req", {31'b0, imem_req_o}, 32'd1);
        check("c0_addr", imem_addr_o, 32'd0);

        tick(2); // c2: first word in IF/ID, next fetch at 4
        check("c2_instr", if_id_instr_o, 32'h0050_0093);
        check("c2_pc", if_id_pc_o, 32'd0);
        check("c2_pc4", if_id_pc_plus4_o, 32'd4);
        check("c2_valid", {31'b0, if_id_valid_o}, 32'd1);
        check("c2_req", {31'b0, imem_req_o}, 32'd1);
        check("c2_addr", imem_addr_o, 32'd4);

        tick(1); // c3: bubble keeps pc fields
        check("c3_valid", {31'b0, if_id_valid_o}, 32'd0);
        check("c3_instr", if_id_instr_o, NOP);
        check("c3_pc", if_id_pc_o, 32'd0);
        k    = 3;
        base = req_addr_q.size();

        tick(3); // c6
        check("c6_valid", {31'b0, if_id_valid_o}, 32'd0);
        check("c6_pc", if_id_pc_o, 32'd4);

        tick(6); // c12: word 12 in IF/ID, stall for 5 cycles across rvalid
        check("c12_pc", if_id_pc_o, 32'd12);
        stall_i = 1'b1;

        tick(2); // c14
        check("stall_pc", if_id_pc_o, 32'd12);
        check("stall_instr", if_id_instr_o, mem_word(32'd12));
        check("stall_valid", {31'b0, if_id_valid_o}, 32'd1);

        tick(2); // c16
        check("stall_pc2", if_id_pc_o, 32'd12);
        check("hold_req", {31'b0, imem_req_o}, 32'd0);

        tick(1); // c17: stall drops
        stall_i = 1'b0;
        check("hold_req2", {31'b0, imem_req_o}, 32'd0);
        check("stream_n", 32'(req_addr_q.size() - base), 32'd3);
        check("stream_a0", req_addr_q[base], 32'd8);
        check("stream_a1", req_addr_q[base+1], 32'd12);
        check("stream_a2", req_addr_q[base+2], 32'd16);
        check("stream_gap0", 32'(req_cyc_q[base+1] - req_cyc_q[base]), 32'd4);
        check("stream_gap1", 32'(req_cyc_q[base+2] - req_cyc_q[base+1]), 32'd4);

        tick(1); // c18: held word delivered
        check("unstall_pc", if_id_pc_o, 32'd16);
        check("unstall_valid", {31'b0, if_id_valid_o}, 32'd1);
        check("unstall_addr", imem_addr_o, 32'd20);

        tick(1); // c19: WAIT, redirect + flush
        redirect_i    = 1'b1;
        flush_i       = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        tick(1);
        redirect_i = 1'b0;
        flush_i    = 1'b0;
        check("flush_valid", {31'b0, if_id_valid_o}, 32'd0);
        check("flush_instr", if_id_instr_o, NOP);
        wait_req(a);
        check("redir_addr", a, 32'h0000_0100);

        // redirect in ISSUE with unaligned target
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0203;
        tick(1);
        redirect_i = 1'b0;
        wait_req(a);
        check("align_addr", a, 32'h0000_0200);
        wait_req(a);
        check("align_next", a, 32'h0000_0204);

        // wrap-around
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick(1);
        redirect_i = 1'b0;
        wait_req(a);
        check("wrap_addr", a, 32'hFFFF_FFFC);
        wait_req(a);
        check("wrap_next", a, 32'd0);

        // flush alone while IF/ID holds a real instruction
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        check("flush1_valid", {31'b0, if_id_valid_o}, 32'd0);
        check("flush1_instr", if_id_instr_o, NOP);
        check("flush1_pc", if_id_pc_o, 32'hFFFF_FFFC);
        check("flush1_pc4", if_id_pc_plus4_o, 32'd0);
        wait_req(a);
        check("flush1_next", a, 32'd4);

        // async reset during WAIT, stray rvalid right after release
        tick(1);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("arst");
        tick(1);
        rst_ni = 1'b1;
        stray_set++;
        d0 = delivered;
        #1;
        check("arst_req", {31'b0, imem_req_o}, 32'd1);
        check("arst_addr", imem_addr_o, 32'd0);
        for (int n = 0; n < 30 && delivered == d0; n++) tick(1);
        check("arst_refetch", 32'(delivered - d0), 32'd1);

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
